// File: rtl/gray_counter.sv
// gray_counter: synchronous WIDTH-bit Gray-code counter.
// Counts up or down, supports parallel load of a binary value, and flags
// terminal count (TC, combinational) and wrap-around (WRAP, registered pulse).
// Optional feature macro: GRAY_BIN_OUT_EN adds the registered binary output BIN.
// The counter state is held in binary; GRAY is re-encoded from the next binary
// value on the same edge, so no input reaches GRAY/BIN without a register.
module gray_counter #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_BIN = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_BIN,
    output logic [WIDTH-1:0] GRAY,
    output logic             TC,
    output logic             WRAP
`ifdef GRAY_BIN_OUT_EN
    ,
    output logic [WIDTH-1:0] BIN
`endif
);

    // Binary -> reflected Gray code.
    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] next_count;
    logic             at_max;
    logic             at_min;

    assign at_max = (count == '1);
    assign at_min = (count == '0);

    // Terminal count: the enabled step about to leave the range end.
    always_comb begin
        TC = EN & ((UP & at_max) | (~UP & at_min));
    end

    // Next binary value with priority LOAD > EN > hold (reset handled in the register).
    always_comb begin
        next_count = count;
        if (LOAD) begin
            next_count = LOAD_BIN;
        end else if (EN) begin
            if (UP) begin
                next_count = count + 1'b1;
            end else begin
                next_count = count - 1'b1;
            end
        end
    end

    // State, Gray output and wrap pulse; reset discards any in-flight step.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RESET_BIN;
            GRAY  <= to_gray(RESET_BIN);
            WRAP  <= 1'b0;
        end else begin
            count <= next_count;
            GRAY  <= to_gray(next_count);
            // A load always clears the pulse; an enabled step at TC wraps.
            WRAP  <= ~LOAD & TC;
        end
    end

`ifdef GRAY_BIN_OUT_EN
    assign BIN = count;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Testbench for gray_counter (WIDTH=4): directed vector table, full up/down
// sweeps, reset-over-load corner case and a randomized scoreboard run.
// Builds with or without GRAY_BIN_OUT_EN.
module tb_gray_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         EN = 1'b0;
    logic         UP = 1'b0;
    logic         LOAD = 1'b0;
    logic [W-1:0] LOAD_BIN = '0;
    logic [W-1:0] GRAY;
    logic         TC;
    logic         WRAP;
`ifdef GRAY_BIN_OUT_EN
    logic [W-1:0] BIN;
`endif

    gray_counter #(.WIDTH(W), .RESET_BIN(4'd0)) dut (
        .clk      (clk),
        .rst      (rst),
        .EN       (EN),
        .UP       (UP),
        .LOAD     (LOAD),
        .LOAD_BIN (LOAD_BIN),
        .GRAY     (GRAY),
        .TC       (TC),
        .WRAP     (WRAP)
`ifdef GRAY_BIN_OUT_EN
        ,
        .BIN      (BIN)
`endif
    );

    always #5 clk = ~clk;

    // 4-bit reflected Gray sequence indexed by binary count.
    logic [3:0] g4 [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    typedef struct {
        logic       r, e, u, l;
        logic [3:0] lb;
        logic       tc;
        logic [3:0] g;
        logic       w;
        logic [3:0] b;
    } vec_t;

    typedef struct {
        string      nm;
        logic [3:0] gray;
        logic       wrap;
        logic [3:0] bin;
        logic       onebit;
        logic [3:0] prev;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Drive one cycle of inputs, check TC before the edge, queue the expected
    // post-edge state, then pop and compare it after the edge.
    task automatic cycle(input string nm, input logic r, input logic e, input logic u,
                         input logic l, input logic [3:0] lb, input logic chk_tc,
                         input logic tc_exp, input logic [3:0] g_exp, input logic w_exp,
                         input logic [3:0] b_exp);
        exp_t x;
        rst = r; EN = e; UP = u; LOAD = l; LOAD_BIN = lb;
        @(negedge clk);
        if (chk_tc) check({nm, " TC"}, {31'd0, TC}, {31'd0, tc_exp});
        x.nm = nm;
        x.gray = g_exp;
        x.wrap = w_exp;
        x.bin = b_exp;
        x.onebit = !r && !l && e;
        x.prev = GRAY;
        sbq.push_back(x);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            x = sbq.pop_front();
            check({x.nm, " GRAY"}, {28'd0, GRAY}, {28'd0, x.gray});
            check({x.nm, " WRAP"}, {31'd0, WRAP}, {31'd0, x.wrap});
`ifdef GRAY_BIN_OUT_EN
            check({x.nm, " BIN"}, {28'd0, BIN}, {28'd0, x.bin});
`endif
            if (x.onebit)
                check({x.nm, " onebit"}, $countones(GRAY ^ x.prev), 32'd1);
        end
    endtask

    vec_t tbl[13];

    initial begin
        logic [3:0] m;
        logic       r, e, u, l, tce, we;
        logic [3:0] lb, nx;

        //            r  e  u  l  lb     tc  gray  w  bin
        tbl[0]  = '{1'b0,1'b1,1'b1,1'b1,4'hB, 1'b0,4'hE,1'b0,4'hB}; // load beats EN
        tbl[1]  = '{1'b0,1'b1,1'b1,1'b0,4'h0, 1'b0,4'hA,1'b0,4'hC};
        tbl[2]  = '{1'b0,1'b1,1'b1,1'b0,4'h0, 1'b0,4'hB,1'b0,4'hD};
        tbl[3]  = '{1'b0,1'b1,1'b1,1'b0,4'h0, 1'b0,4'h9,1'b0,4'hE};
        tbl[4]  = '{1'b0,1'b1,1'b1,1'b0,4'h0, 1'b0,4'h8,1'b0,4'hF};
        tbl[5]  = '{1'b0,1'b1,1'b1,1'b0,4'h0, 1'b1,4'h0,1'b1,4'h0}; // wrap up
        tbl[6]  = '{1'b0,1'b0,1'b1,1'b0,4'h0, 1'b0,4'h0,1'b0,4'h0}; // hold
        tbl[7]  = '{1'b0,1'b1,1'b0,1'b0,4'h0, 1'b1,4'h8,1'b1,4'hF}; // wrap down
        tbl[8]  = '{1'b0,1'b1,1'b1,1'b0,4'h0, 1'b1,4'h0,1'b1,4'h0}; // reverse and wrap
        tbl[9]  = '{1'b0,1'b1,1'b1,1'b1,4'h7, 1'b0,4'h4,1'b0,4'h7};
        tbl[10] = '{1'b1,1'b1,1'b1,1'b1,4'hF, 1'b0,4'h0,1'b0,4'h0}; // rst beats LOAD/EN
        tbl[11] = '{1'b0,1'b1,1'b0,1'b0,4'h0, 1'b1,4'h8,1'b1,4'hF};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b0,4'h0, 1'b0,4'h8,1'b0,4'hF};

        @(posedge clk);
        #1;

        // Reset state
        cycle("reset", 1'b1, 1'b1, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);

        // Directed vector table
        for (int i = 0; i < 13; i++)
            cycle($sformatf("vec%0d", i), tbl[i].r, tbl[i].e, tbl[i].u, tbl[i].l, tbl[i].lb,
                  1'b1, tbl[i].tc, tbl[i].g, tbl[i].w, tbl[i].b);

        // Full up sweep from 0
        cycle("rst_up", 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
        for (int i = 0; i < 16; i++)
            cycle($sformatf("up%0d", i), 1'b0, 1'b1, 1'b1, 1'b0, 4'h0,
                  1'b1, (i == 15), g4[(i + 1) % 16], (i == 15), 4'((i + 1) % 16));

        // Full down sweep from 0
        cycle("rst_dn", 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
        for (int i = 0; i < 16; i++)
            cycle($sformatf("dn%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 4'h0,
                  1'b1, (i == 0), g4[15 - i], (i == 0), 4'(15 - i));

        // Count up to 7, then reset with EN and LOAD asserted
        cycle("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
        for (int i = 0; i < 7; i++)
            cycle($sformatf("mid%0d", i), 1'b0, 1'b1, 1'b1, 1'b0, 4'h0,
                  1'b1, 1'b0, g4[i + 1], 1'b0, 4'(i + 1));
        cycle("mid_rst", 1'b1, 1'b1, 1'b1, 1'b1, 4'h9, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);

        // Randomized run against a binary reference model
        m = 4'h0;
        for (int i = 0; i < 1000; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            l  = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = $urandom_range(0, 1);
            lb = 4'($urandom_range(0, 15));
            tce = e & ((u & (m == 4'hF)) | (~u & (m == 4'h0)));
            we = 1'b0;
            if (r) nx = 4'h0;
            else if (l) nx = lb;
            else if (e) begin
                nx = u ? m + 4'd1 : m - 4'd1;
                we = tce;
            end else nx = m;
            cycle($sformatf("rnd%0d", i), r, e, u, l, lb, 1'b1, tce, g4[nx], we, nx);
            m = nx;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
